// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, Funct3 encodings and decode helpers for the data-memory stage
package dmem_pkg;

   // Access FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2,
      ST_ERR  = 2'd3
   } state_t;

   // Access width decoded from the low two Funct3 bits
   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_t;

   // RV32I load/store Funct3 encodings
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Width of an access; the unsigned variants share the signed ones' low bits
   function automatic size_t f3_size(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return SZ_BYTE;
         2'b01:   return SZ_HALF;
         default: return SZ_WORD;
      endcase
   endfunction

   // Stores have no unsigned forms, so fewer encodings are legal for them
   function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
      if (is_store)
         return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
             (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

   // Halfwords need an even address, words a multiple of four
   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] low);
      case (f3_size(f3))
         SZ_HALF: return low[0];
         SZ_WORD: return low != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/dmem_load_align.sv
// rtl/dmem_load_align.sv - extracts and extends a byte/half/word from a raw RAM word
module dmem_load_align
   import dmem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  byte_sel,
   input  logic [2:0]  funct3,
   output logic [31:0] value
);

   logic [31:0] shifted;

   // Move the addressed lane down to bit 0, then sign- or zero-extend by access type
   always_comb begin
      shifted = word >> {byte_sel, 3'b000};
      case (funct3)
         F3_B:    value = {{24{shifted[7]}}, shifted[7:0]};
         F3_H:    value = {{16{shifted[15]}}, shifted[15:0]};
         F3_BU:   value = {24'd0, shifted[7:0]};
         F3_HU:   value = {16'd0, shifted[15:0]};
         default: value = shifted;
      endcase
   end

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - data-memory stage: byte-addressable RAM with size/sign handling and wait states
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 9,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [2:0]        Funct3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data,
   output logic              stall,
   output logic              mem_err,
   output logic              busy_o
);

   localparam int         WORDS     = 2 ** (ADDR_W - 2);
   localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   state_t              state;
   state_t              state_nxt;
   logic [3:0]          cnt;

   logic [ADDR_W-1:0]   cap_addr;
   logic [2:0]          cap_f3;
   logic [DATA_W-1:0]   cap_wdata;
   logic                cap_write;

   logic                req;
   logic                acc_err;
   logic                in_idle;
   logic                commit;

   logic [ADDR_W-1:0]   eff_addr;
   logic [2:0]          eff_f3;
   logic [DATA_W-1:0]   eff_wdata;
   logic                eff_write;
   logic [ADDR_W-3:0]   word_idx;

   logic [3:0]          be;
   logic [DATA_W-1:0]   wdata_lane;
   logic [DATA_W-1:0]   raw_word;
   logic [DATA_W-1:0]   load_value;

   logic [DATA_W-1:0]   mem [WORDS];

   assign req     = MemRead | MemWrite;
   assign acc_err = (MemRead & MemWrite) |
                    ~f3_legal(Funct3, MemWrite) |
                    misaligned(Funct3, addr[1:0]);
   assign in_idle = (state == ST_IDLE);

   // With zero wait states the commit happens on the same edge as the capture,
   // so the RAM port works from the live request while idle, otherwise from the captured copy.
   assign eff_addr  = in_idle ? addr     : cap_addr;
   assign eff_f3    = in_idle ? Funct3   : cap_f3;
   assign eff_wdata = in_idle ? wr_data  : cap_wdata;
   assign eff_write = in_idle ? MemWrite : cap_write;
   assign word_idx  = eff_addr[ADDR_W-1:2];

   // The RAM is touched only on the edge that enters DONE; reset gating drops in-flight stores
   assign commit = reset & (state_nxt == ST_DONE);

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (req) begin
               if (acc_err)              state_nxt = ST_ERR;
               else if (WAIT_CYCLES > 0) state_nxt = ST_WAIT;
               else                      state_nxt = ST_DONE;
            end
         end
         ST_WAIT: begin
            if (cnt == 4'd0) state_nxt = ST_DONE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Byte enables and lane-replicated store data from the low address bits and access width
   always_comb begin
      be         = 4'b1111;
      wdata_lane = eff_wdata;
      case (f3_size(eff_f3))
         SZ_BYTE: begin
            be         = 4'b0001 << eff_addr[1:0];
            wdata_lane = {4{eff_wdata[7:0]}};
         end
         SZ_HALF: begin
            be         = eff_addr[1] ? 4'b1100 : 4'b0011;
            wdata_lane = {2{eff_wdata[15:0]}};
         end
         default: begin
            be         = 4'b1111;
            wdata_lane = eff_wdata;
         end
      endcase
   end

   assign raw_word = mem[word_idx];

   dmem_load_align u_align (
      .word     (raw_word),
      .byte_sel (eff_addr[1:0]),
      .funct3   (eff_f3),
      .value    (load_value)
   );

   // RAM write port: only enabled byte lanes of the committed store are updated
   always_ff @(posedge clk) begin
      if (commit && eff_write) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[word_idx][8*i +: 8] <= wdata_lane[8*i +: 8];
         end
      end
   end

   // FSM, wait counter, request capture and registered load result
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         cnt       <= 4'd0;
         cap_addr  <= '0;
         cap_f3    <= 3'd0;
         cap_wdata <= '0;
         cap_write <= 1'b0;
         rd_data   <= '0;
      end else begin
         state <= state_nxt;
         if (in_idle && req && !acc_err) begin
            cap_addr  <= addr;
            cap_f3    <= Funct3;
            cap_wdata <= wr_data;
            cap_write <= MemWrite;
            cnt       <= WAIT_LOAD;
         end else if (state == ST_WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
         if (commit && !eff_write) rd_data <= load_value;
      end
   end

   // Pipeline hold: the request itself stalls in IDLE, WAIT always stalls, nothing while in reset
   always_comb begin
      stall = 1'b0;
      if (reset) begin
         case (state)
            ST_IDLE: stall = req;
            ST_WAIT: stall = 1'b1;
            default: stall = 1'b0;
         endcase
      end
   end

   assign mem_err = (state == ST_ERR);
   assign busy_o  = (state != ST_IDLE);

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - table-driven bench for dmem_ctrl at 0, 1 and 3 wait states
module tb_dmem_ctrl;

   typedef struct {
      int          d;
      logic        r;
      logic        w;
      logic [2:0]  f;
      logic [8:0]  a;
      logic [31:0] wd;
      int          stl;
      logic        err;
      logic [31:0] rdx;
   } vec_t;

   logic        clk = 1'b0;
   logic [2:0]  rst_n;
   logic [2:0]  mrd;
   logic [2:0]  mwr;
   logic [2:0]  f3   [3];
   logic [8:0]  adr  [3];
   logic [31:0] wdat [3];
   logic [31:0] rdat [3];
   logic [2:0]  stall;
   logic [2:0]  mem_err;
   logic [2:0]  busy;

   int n_vec = 0;
   int n_bad = 0;
   vec_t vt[$];

   always #5 clk = ~clk;

   dmem_ctrl #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(1)) u0 (
      .clk(clk), .reset(rst_n[0]), .MemRead(mrd[0]), .MemWrite(mwr[0]), .Funct3(f3[0]),
      .addr(adr[0]), .wr_data(wdat[0]), .rd_data(rdat[0]), .stall(stall[0]),
      .mem_err(mem_err[0]), .busy_o(busy[0]));

   dmem_ctrl #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(0)) u1 (
      .clk(clk), .reset(rst_n[1]), .MemRead(mrd[1]), .MemWrite(mwr[1]), .Funct3(f3[1]),
      .addr(adr[1]), .wr_data(wdat[1]), .rd_data(rdat[1]), .stall(stall[1]),
      .mem_err(mem_err[1]), .busy_o(busy[1]));

   dmem_ctrl #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(3)) u2 (
      .clk(clk), .reset(rst_n[2]), .MemRead(mrd[2]), .MemWrite(mwr[2]), .Funct3(f3[2]),
      .addr(adr[2]), .wr_data(wdat[2]), .rd_data(rdat[2]), .stall(stall[2]),
      .mem_err(mem_err[2]), .busy_o(busy[2]));

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got %08h expected %08h", nm, got, exp);
      end
   endtask

   task automatic run_access(input int d, input logic r, input logic w, input logic [2:0] f,
                             input logic [8:0] a, input logic [31:0] data, input int exp_stl,
                             input logic exp_err, input logic [31:0] exp_rd, input string tag);
      int n;
      @(negedge clk);
      mrd[d] = r; mwr[d] = w; f3[d] = f; adr[d] = a; wdat[d] = data;
      #1;
      n = 0;
      while (stall[d] === 1'b1 && n < 40) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk($sformatf("%s stall_cycles", tag), 32'(n), 32'(exp_stl));
      chk($sformatf("%s mem_err", tag), {31'd0, mem_err[d]}, {31'd0, exp_err});
      chk($sformatf("%s rd_data", tag), rdat[d], exp_rd);
      @(negedge clk);
      mrd[d] = 1'b0; mwr[d] = 1'b0;
      #1;
      chk($sformatf("%s back_idle", tag), {29'd0, busy[d], mem_err[d], stall[d]}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 3'b000; mrd = 3'b000; mwr = 3'b000;
      for (int i = 0; i < 3; i++) begin
         f3[i] = 3'b010; adr[i] = 9'd0; wdat[i] = 32'd0;
      end

      //        d  r     w     f3      addr    wr_data       stl err   rd_data
      vt.push_back('{0, 1'b0, 1'b1, 3'b010, 9'h010, 32'hDEADBEEF, 2, 1'b0, 32'h00000000});
      vt.push_back('{0, 1'b1, 1'b0, 3'b010, 9'h010, 32'h0,        2, 1'b0, 32'hDEADBEEF});
      vt.push_back('{0, 1'b0, 1'b1, 3'b000, 9'h013, 32'h00000080, 2, 1'b0, 32'hDEADBEEF});
      vt.push_back('{0, 1'b1, 1'b0, 3'b000, 9'h013, 32'h0,        2, 1'b0, 32'hFFFFFF80});
      vt.push_back('{0, 1'b1, 1'b0, 3'b100, 9'h013, 32'h0,        2, 1'b0, 32'h00000080});
      vt.push_back('{0, 1'b1, 1'b0, 3'b010, 9'h010, 32'h0,        2, 1'b0, 32'h80ADBEEF});
      vt.push_back('{0, 1'b1, 1'b0, 3'b010, 9'h011, 32'h0,        1, 1'b1, 32'h80ADBEEF});
      vt.push_back('{0, 1'b0, 1'b1, 3'b100, 9'h010, 32'h11111111, 1, 1'b1, 32'h80ADBEEF});
      vt.push_back('{0, 1'b1, 1'b0, 3'b000, 9'h010, 32'h0,        2, 1'b0, 32'hFFFFFFEF});
      vt.push_back('{0, 1'b1, 1'b0, 3'b001, 9'h012, 32'h0,        2, 1'b0, 32'hFFFF80AD});
      vt.push_back('{1, 1'b0, 1'b1, 3'b010, 9'h020, 32'h11223344, 1, 1'b0, 32'h00000000});
      vt.push_back('{1, 1'b0, 1'b1, 3'b001, 9'h022, 32'hFFFF8001, 1, 1'b0, 32'h00000000});
      vt.push_back('{1, 1'b1, 1'b0, 3'b001, 9'h022, 32'h0,        1, 1'b0, 32'hFFFF8001});
      vt.push_back('{1, 1'b1, 1'b0, 3'b101, 9'h022, 32'h0,        1, 1'b0, 32'h00008001});
      vt.push_back('{1, 1'b0, 1'b1, 3'b001, 9'h023, 32'h00005555, 1, 1'b1, 32'h00008001});
      vt.push_back('{1, 1'b1, 1'b0, 3'b010, 9'h020, 32'h0,        1, 1'b0, 32'h80013344});
      vt.push_back('{1, 1'b1, 1'b0, 3'b011, 9'h020, 32'h0,        1, 1'b1, 32'h80013344});
      vt.push_back('{1, 1'b1, 1'b1, 3'b010, 9'h020, 32'h0,        1, 1'b1, 32'h80013344});
      vt.push_back('{1, 1'b1, 1'b0, 3'b000, 9'h021, 32'h0,        1, 1'b0, 32'h00000033});
      vt.push_back('{1, 1'b0, 1'b1, 3'b010, 9'h1FC, 32'hCAFEF00D, 1, 1'b0, 32'h00000033});
      vt.push_back('{1, 1'b1, 1'b0, 3'b010, 9'h1FC, 32'h0,        1, 1'b0, 32'hCAFEF00D});
      vt.push_back('{1, 1'b1, 1'b0, 3'b100, 9'h1FF, 32'h0,        1, 1'b0, 32'h000000CA});
      vt.push_back('{1, 1'b1, 1'b0, 3'b001, 9'h1FE, 32'h0,        1, 1'b0, 32'hFFFFCAFE});
      vt.push_back('{1, 1'b0, 1'b1, 3'b000, 9'h1FD, 32'h123456AB, 1, 1'b0, 32'hFFFFCAFE});
      vt.push_back('{1, 1'b1, 1'b0, 3'b010, 9'h1FC, 32'h0,        1, 1'b0, 32'hCAFEAB0D});

      // reset state of every instance
      repeat (3) @(negedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("reset%0d rd_data", d), rdat[d], 32'd0);
         chk($sformatf("reset%0d flags", d), {29'd0, busy[d], mem_err[d], stall[d]}, 32'd0);
      end
      @(negedge clk);
      rst_n = 3'b111;

      foreach (vt[i])
         run_access(vt[i].d, vt[i].r, vt[i].w, vt[i].f, vt[i].a, vt[i].wd,
                    vt[i].stl, vt[i].err, vt[i].rdx, $sformatf("vec%0d", i));

      // three wait states: seed a word, then reset in the middle of a store to it
      run_access(2, 1'b0, 1'b1, 3'b010, 9'h030, 32'hA5A5A5A5, 4, 1'b0, 32'h0, "seed_sw");
      run_access(2, 1'b1, 1'b0, 3'b010, 9'h030, 32'h0, 4, 1'b0, 32'hA5A5A5A5, "seed_lw");

      @(negedge clk);
      mwr[2] = 1'b1; f3[2] = 3'b010; adr[2] = 9'h030; wdat[2] = 32'h12345678;
      #1;
      chk("rst_mid idle_stall", {31'd0, stall[2]}, 32'd1);
      @(negedge clk);
      #1;
      chk("rst_mid wait_busy", {30'd0, busy[2], stall[2]}, 32'd3);
      rst_n[2] = 1'b0;
      #1;
      chk("rst_mid flags", {29'd0, busy[2], mem_err[2], stall[2]}, 32'd0);
      chk("rst_mid rd_data", rdat[2], 32'd0);
      repeat (4) @(negedge clk);
      mwr[2] = 1'b0;
      rst_n[2] = 1'b1;
      run_access(2, 1'b1, 1'b0, 3'b010, 9'h030, 32'h0, 4, 1'b0, 32'hA5A5A5A5, "rst_mid lw_old");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
